dx_rnd_src_sampler: RTL and testbench

- Consumer end of the ring-oscillator entropy source.
- Drives the oscillator's enable and chain select, then samples its asynchronous rnd_src output in the rng_clk domain through a 2-flop synchronizer.
- Decimates the samples and packs them into WORD_W-bit words.
- Presents each word to the TRNG core over a valid/ready handshake.

---
 rtl/dx_rnd_src_sampler.sv | 216 +++++++++++++++++++++
 tb/tb_dx_rnd_src_sampler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dx_rnd_src_sampler.sv
// dx_rnd_src_sampler
//
// Consumer end of the ring-oscillator entropy source. It enables the
// oscillator and selects its chain. It brings the asynchronous oscillator
// output into the rng_clk domain through a two-flop synchronizer. It then
// decimates the samples, packs them into WORD_W-bit words and hands each
// word to the TRNG core over a valid/ready handshake.
//
// Optional build macro: DX_TRNG_VON_NEUMANN_EN
//   When defined, samples are debiased in non-overlapping pairs
//   (01 -> 0, 10 -> 1, 00/11 dropped). The extra output vn_discard
//   pulses for one cycle for each dropped pair.
//
// Ports:
//   rng_clk      in   sampling clock, rising edge
//   rng_rst_n    in   synchronous reset, active low
//   trng_en      in   level request to collect entropy
//   src_sel      in   chain select, latched when leaving IDLE
//   sample_div   in   sample every sample_div+1 cycles, latched when leaving IDLE
//   rnd_src      in   raw oscillator output (asynchronous)
//   rnd_src_en   out  oscillator enable
//   rnd_src_sel  out  latched chain select
//   rnd_data     out  collected word
//   rnd_valid    out  rnd_data holds a complete word
//   rnd_ready    in   consumer accepts the word
//   vn_discard   out  (macro only) one-cycle pulse per dropped pair
//   busy         out  state is not IDLE

module dx_rnd_src_sampler #(
  parameter int WORD_W        = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter int DIV_W         = 8
) (
  input  logic              rng_clk,
  input  logic              rng_rst_n,
  input  logic              trng_en,
  input  logic [1:0]        src_sel,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic              rnd_src,
  output logic              rnd_src_en,
  output logic [1:0]        rnd_src_sel,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
`ifdef DX_TRNG_VON_NEUMANN_EN
  output logic              vn_discard,
`endif
  output logic              busy
);

  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0] LAST_WARM = WCW'(WARMUP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WARMUP  = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0]        state_q;
  logic              s0_q;
  logic              s1_q;
  logic [DIV_W-1:0]  div_q;
  logic [WCW-1:0]    warm_cnt_q;
  logic [DIV_W-1:0]  samp_cnt_q;
  logic [BCW-1:0]    bit_cnt_q;
  logic [WORD_W-1:0] shift_q;

  logic sample_tick;
  logic emit_valid;
  logic emit_bit;
  logic word_done;

  assign busy = (state_q != ST_IDLE);

  // A sample is taken only while collecting and still enabled. An abort
  // cycle therefore never produces a bit or a discard pulse.
  assign sample_tick = (state_q == ST_COLLECT) && trng_en && (samp_cnt_q == div_q);

`ifdef DX_TRNG_VON_NEUMANN_EN
  logic vn_phase_q;
  logic vn_first_q;

  // The second sample of a pair emits the first sample's value when the
  // two differ. This gives 01 -> 0 and 10 -> 1.
  always_comb begin
    emit_valid = sample_tick && vn_phase_q && (vn_first_q != s1_q);
    emit_bit   = vn_first_q;
  end

  // Pair tracking. The phase is held clear outside COLLECT, so every entry
  // into COLLECT (from WARMUP or after a handshake) starts a fresh pair.
  always_ff @(posedge rng_clk) begin
    if (!rng_rst_n) begin
      vn_phase_q <= 1'b0;
      vn_first_q <= 1'b0;
      vn_discard <= 1'b0;
    end else begin
      vn_discard <= 1'b0;
      if (state_q != ST_COLLECT) begin
        vn_phase_q <= 1'b0;
      end else if (sample_tick) begin
        if (!vn_phase_q) begin
          vn_first_q <= s1_q;
          vn_phase_q <= 1'b1;
        end else begin
          vn_phase_q <= 1'b0;
          vn_discard <= (vn_first_q == s1_q);
        end
      end
    end
  end
`else
  always_comb begin
    emit_valid = sample_tick;
    emit_bit   = s1_q;
  end
`endif

  assign word_done = emit_valid && (bit_cnt_q == LAST_BIT);

  // Two-flop synchronizer for the asynchronous oscillator output.
  always_ff @(posedge rng_clk) begin
    if (!rng_rst_n) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= rnd_src;
      s1_q <= s0_q;
    end
  end

  // Main control. Partial bits collect in shift_q. rnd_data is written only
  // when a word completes, so an aborted word never disturbs it.
  always_ff @(posedge rng_clk) begin
    if (!rng_rst_n) begin
      state_q     <= ST_IDLE;
      rnd_src_en  <= 1'b0;
      rnd_src_sel <= 2'd0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      div_q       <= '0;
      warm_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rnd_src_en <= 1'b0;
          if (trng_en) begin
            rnd_src_sel <= src_sel;
            div_q       <= sample_div;
            warm_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rnd_src_en  <= 1'b1;
            state_q     <= ST_WARMUP;
          end
        end

        ST_WARMUP: begin
          if (!trng_en) begin
            rnd_src_en <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (warm_cnt_q == LAST_WARM) begin
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= ST_COLLECT;
          end else begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
          end
        end

        ST_COLLECT: begin
          if (!trng_en) begin
            rnd_src_en <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (sample_tick) begin
            samp_cnt_q <= '0;
            if (word_done) begin
              rnd_data  <= {shift_q[WORD_W-2:0], emit_bit};
              rnd_valid <= 1'b1;
              state_q   <= ST_HOLD;
            end else if (emit_valid) begin
              shift_q   <= {shift_q[WORD_W-2:0], emit_bit};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
          end
        end

        ST_HOLD: begin
          // The oscillator follows trng_en one cycle late while the word waits.
          rnd_src_en <= trng_en;
          if (rnd_valid && rnd_ready) begin
            rnd_valid  <= 1'b0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= trng_en ? ST_COLLECT : ST_IDLE;
          end
        end

        default: begin
          rnd_src_en <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dx_rnd_src_sampler.sv
// tb_dx_rnd_src_sampler
//
// Self-checking bench for dx_rnd_src_sampler with WORD_W=8,
// WARMUP_CYCLES=16 and DIV_W=8. A table of word-capture vectors is
// followed by hand-written sequences for reset, back-pressure and abort.
// Building with DX_TRNG_VON_NEUMANN_EN runs the debias sequence instead.

module tb_dx_rnd_src_sampler;

  localparam int WORD_W = 8;
  localparam int WARM   = 16;
  localparam int DIV_W  = 8;
  localparam int BOUND  = 700;

  logic              rng_clk;
  logic              rng_rst_n;
  logic              trng_en;
  logic [1:0]        src_sel;
  logic [DIV_W-1:0]  sample_div;
  logic              rnd_src;
  logic              rnd_src_en;
  logic [1:0]        rnd_src_sel;
  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_ready;
  logic              busy;
`ifdef DX_TRNG_VON_NEUMANN_EN
  logic              vn_discard;
`endif

  int errors = 0;
  int checks = 0;

  dx_rnd_src_sampler #(
    .WORD_W       (WORD_W),
    .WARMUP_CYCLES(WARM),
    .DIV_W        (DIV_W)
  ) dut (
    .rng_clk    (rng_clk),
    .rng_rst_n  (rng_rst_n),
    .trng_en    (trng_en),
    .src_sel    (src_sel),
    .sample_div (sample_div),
    .rnd_src    (rnd_src),
    .rnd_src_en (rnd_src_en),
    .rnd_src_sel(rnd_src_sel),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
`ifdef DX_TRNG_VON_NEUMANN_EN
    .vn_discard (vn_discard),
`endif
    .busy       (busy)
  );

  initial rng_clk = 1'b0;
  always #5 rng_clk = ~rng_clk;

  typedef struct {
    logic [7:0] div;
    logic [1:0] sel;
    logic [7:0] pat;
    logic       chg;
    int         lat;
    logic [7:0] exp_data;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[6];

  // Advance past the next rising edge and settle before sampling outputs.
  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one word from IDLE. rnd_src is scheduled so that the synchronized
  // bit seen at each expected sample edge is the next pattern bit, MSB first.
  // Noise is driven on every other cycle so that wrong spacing corrupts the
  // word. At the end the word is accepted with trng_en low, back to IDLE.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    int d;
    int rel;
    int k;
    lat = -1;
    d = int'(v.div);
    sample_div = v.div;
    src_sel    = v.sel;
    rnd_ready  = 1'b0;
    trng_en    = 1'b1;
    for (int j = 0; j < BOUND; j++) begin
      rel = j + 2 - WARM;
      k   = (rel > 0 && (rel % (d + 1)) == 0) ? rel / (d + 1) : 0;
      if (k >= 1 && k <= 8) rnd_src = v.pat[8 - k];
      else                  rnd_src = 1'($urandom_range(0, 1));
      if (v.chg && j == 20) begin
        src_sel    = 2'd1;
        sample_div = 8'd0;
      end
      tick();
      if (rnd_valid) begin
        lat = j;
        break;
      end
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(v.lat));
    checkOutput({tag, " data"}, 64'(rnd_data), 64'(v.exp_data));
    checkOutput({tag, " src_sel"}, 64'(rnd_src_sel), 64'(v.exp_sel));
    checkOutput({tag, " src_en"}, 64'(rnd_src_en), 64'd1);
    rnd_ready = 1'b1;
    trng_en   = 1'b0;
    tick();
    rnd_ready = 1'b0;
    checkOutput({tag, " valid after accept"}, 64'(rnd_valid), 64'd0);
    checkOutput({tag, " busy after accept"}, 64'(busy), 64'd0);
    checkOutput({tag, " data kept"}, 64'(rnd_data), 64'(v.exp_data));
  endtask

  initial begin
    int lat;
    int lat2;
    int disc;
    int rel;
    logic stable;
    logic never_valid;
    logic [19:0] vn_stream;

    rng_rst_n  = 1'b0;
    trng_en    = 1'b1;
    src_sel    = 2'd0;
    sample_div = 8'd0;
    rnd_src    = 1'b0;
    rnd_ready  = 1'b0;

    // Reset held with trng_en high, then release into WARMUP and abort.
    repeat (3) tick();
    checkOutput("reset src_en", 64'(rnd_src_en), 64'd0);
    checkOutput("reset valid", 64'(rnd_valid), 64'd0);
    checkOutput("reset data", 64'(rnd_data), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset src_sel", 64'(rnd_src_sel), 64'd0);
    rng_rst_n = 1'b1;
    tick();
    checkOutput("release src_en", 64'(rnd_src_en), 64'd1);
    checkOutput("release busy", 64'(busy), 64'd1);
    trng_en = 1'b0;
    tick();
    checkOutput("warmup abort src_en", 64'(rnd_src_en), 64'd0);
    checkOutput("warmup abort busy", 64'(busy), 64'd0);
    repeat (2) tick();

`ifdef DX_TRNG_VON_NEUMANN_EN
    // Pairs 01,11,10,00,10,10,10,01,01,01 emit 0,1,1,1,1,0,0,0 = 8'h78 after
    // 20 samples and drop two pairs.
    vn_stream  = 20'b0111_1000_1010_1001_0101;
    lat        = -1;
    disc       = 0;
    sample_div = 8'd0;
    trng_en    = 1'b1;
    for (int j = 0; j < BOUND; j++) begin
      rel = j + 2 - WARM;
      if (rel >= 1 && rel <= 20) rnd_src = vn_stream[20 - rel];
      else                       rnd_src = 1'($urandom_range(0, 1));
      tick();
      if (vn_discard) disc++;
      if (rnd_valid) begin
        lat = j;
        break;
      end
    end
    checkOutput("vn latency", 64'(lat), 64'd36);
    checkOutput("vn data", 64'(rnd_data), 64'h78);
    checkOutput("vn discards", 64'(disc), 64'd2);
    rnd_ready = 1'b1;
    trng_en   = 1'b0;
    tick();
    rnd_ready = 1'b0;
    checkOutput("vn valid after accept", 64'(rnd_valid), 64'd0);
`else
    vecs[0] = '{div: 8'd0, sel: 2'd2, pat: 8'hB2, chg: 1'b0, lat: 24, exp_data: 8'hB2, exp_sel: 2'd2};
    vecs[1] = '{div: 8'd3, sel: 2'd1, pat: 8'h5A, chg: 1'b0, lat: 48, exp_data: 8'h5A, exp_sel: 2'd1};
    vecs[2] = '{div: 8'd1, sel: 2'd3, pat: 8'h81, chg: 1'b0, lat: 32, exp_data: 8'h81, exp_sel: 2'd3};
    vecs[3] = '{div: 8'd0, sel: 2'd0, pat: 8'h00, chg: 1'b0, lat: 24, exp_data: 8'h00, exp_sel: 2'd0};
    vecs[4] = '{div: 8'd0, sel: 2'd1, pat: 8'hFF, chg: 1'b0, lat: 24, exp_data: 8'hFF, exp_sel: 2'd1};
    vecs[5] = '{div: 8'd1, sel: 2'd2, pat: 8'hC3, chg: 1'b1, lat: 32, exp_data: 8'hC3, exp_sel: 2'd2};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Back-pressure: the word must stay put until accepted. The next word
    // must follow 32 cycles later without a new warm-up.
    sample_div = 8'd3;
    src_sel    = 2'd0;
    rnd_src    = 1'b1;
    rnd_ready  = 1'b0;
    trng_en    = 1'b1;
    lat        = -1;
    for (int j = 0; j < BOUND; j++) begin
      tick();
      if (rnd_valid) begin
        lat = j;
        break;
      end
    end
    checkOutput("bp first latency", 64'(lat), 64'd48);
    checkOutput("bp first data", 64'(rnd_data), 64'hFF);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (!(rnd_valid === 1'b1 && rnd_data === 8'hFF)) stable = 1'b0;
    end
    checkOutput("bp hold stable", 64'(stable), 64'd1);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    checkOutput("bp valid drop", 64'(rnd_valid), 64'd0);
    checkOutput("bp busy", 64'(busy), 64'd1);
    lat2 = -1;
    for (int j = 1; j < BOUND; j++) begin
      tick();
      if (rnd_valid) begin
        lat2 = j;
        break;
      end
    end
    checkOutput("bp second latency", 64'(lat2), 64'd32);
    checkOutput("bp second data", 64'(rnd_data), 64'hFF);
    trng_en = 1'b0;
    tick();
    checkOutput("hold src_en drop", 64'(rnd_src_en), 64'd0);
    checkOutput("hold valid kept", 64'(rnd_valid), 64'd1);
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    checkOutput("bp end busy", 64'(busy), 64'd0);
    checkOutput("bp end valid", 64'(rnd_valid), 64'd0);

    // Abort after five emitted bits (edges 17..21), with rnd_ready held high
    // to show it has no effect while nothing is valid.
    sample_div = 8'd0;
    rnd_ready  = 1'b1;
    trng_en    = 1'b1;
    never_valid = 1'b1;
    for (int j = 0; j <= 21; j++) begin
      rnd_src = 1'($urandom_range(0, 1));
      tick();
      if (rnd_valid) never_valid = 1'b0;
    end
    trng_en = 1'b0;
    tick();
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort src_en", 64'(rnd_src_en), 64'd0);
    repeat (30) begin
      tick();
      if (rnd_valid) never_valid = 1'b0;
    end
    checkOutput("abort never valid", 64'(never_valid), 64'd1);
    rnd_ready = 1'b0;
    applyStimulus('{div: 8'd0, sel: 2'd3, pat: 8'h3C, chg: 1'b0, lat: 24, exp_data: 8'h3C, exp_sel: 2'd3}, "reenable");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
